// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative RV32M multiply/divide unit. Produces the M-extension
//               result that the ALU selects as mul_din. Radix-2, one bit per
//               clock, followed by a single sign-correction cycle.
// Ports       : clk      - system clock, rising edge
//               rst      - asynchronous active-high reset
//               start    - operation request, sampled only when not busy
//               mode_sel - 8-bit operation code (0x20..0x27 valid)
//               num1     - multiplicand / dividend
//               num2     - multiplier / divisor
//               mul_dout - result, held until the next completion
//               busy     - high while computing (CALC and FIX)
//               done     - one-cycle completion pulse
//               error    - one-cycle pulse for an unsupported mode_sel
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       mode_sel,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic [WIDTH-1:0] mul_dout,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int c_cnt_w = $clog2(ITER);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(ITER - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_fix  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    // Low three bits of the operation code; the upper five must be 5'b00100.
    localparam logic [2:0] c_op_mul    = 3'd0;
    localparam logic [2:0] c_op_mulh   = 3'd1;
    localparam logic [2:0] c_op_mulhsu = 3'd2;
    localparam logic [2:0] c_op_mulhu  = 3'd3;
    localparam logic [2:0] c_op_div    = 3'd4;
    localparam logic [2:0] c_op_divu   = 3'd5;
    localparam logic [2:0] c_op_rem    = 3'd6;
    localparam logic [2:0] c_op_remu   = 3'd7;

    localparam logic [WIDTH-1:0] c_int_min = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 w_accept;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2:0]           r_op;
    logic                 r_neg;       // negate product / quotient
    logic                 r_neg_rem;   // remainder follows dividend sign
    logic                 r_err;
    logic [WIDTH-1:0]     r_opd;       // multiplicand or divisor magnitude
    // Multiply: {partial product high, multiplier shifting out}.
    // Divide:   {partial remainder, dividend shifting out / quotient in}.
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_dout;

    // ------------------------------------------------------------------
    // Operation decode at issue
    // ------------------------------------------------------------------
    logic [2:0]       w_op;
    logic             w_valid;
    logic             w_is_div;
    logic             w_s1;
    logic             w_s2;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic             w_div0;
    logic             w_ovf;
    logic             w_special;
    logic [WIDTH-1:0] w_special_res;

    assign w_op     = mode_sel[2:0];
    assign w_valid  = (mode_sel[7:3] == 5'b00100);
    assign w_is_div = w_op[2];

    // MUL is treated as signed x signed; its low word is identical either way.
    assign w_s1 = num1[WIDTH-1] & ((w_op == c_op_mul) | (w_op == c_op_mulh) |
                                   (w_op == c_op_mulhsu) | (w_op == c_op_div) |
                                   (w_op == c_op_rem));
    assign w_s2 = num2[WIDTH-1] & ((w_op == c_op_mul) | (w_op == c_op_mulh) |
                                   (w_op == c_op_div) | (w_op == c_op_rem));

    assign w_mag1 = w_s1 ? -num1 : num1;
    assign w_mag2 = w_s2 ? -num2 : num2;

    assign w_div0    = w_is_div & (num2 == '0);
    assign w_ovf     = ((w_op == c_op_div) | (w_op == c_op_rem)) &
                       (num1 == c_int_min) & (num2 == '1);
    assign w_special = w_div0 | w_ovf;

    // op[1] distinguishes REM/REMU from DIV/DIVU.
    always_comb begin
        w_special_res = '0;
        if (w_div0) begin
            w_special_res = w_op[1] ? num1 : '1;
        end else begin
            w_special_res = w_op[1] ? '0 : c_int_min;
        end
    end

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_nxt;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_diff;
    logic                 w_ge;
    logic [2*WIDTH-1:0]   w_div_nxt;

    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                       (r_acc[0] ? {1'b0, r_opd} : {(WIDTH+1){1'b0}});
    assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Remainder shifted left with the next dividend bit; the borrow of the
    // trial subtraction tells whether the divisor fits.
    assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff    = w_rem_sh - {1'b0, r_opd};
    assign w_ge      = ~w_diff[WIDTH];
    assign w_div_nxt = {(w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_ge};

    // ------------------------------------------------------------------
    // Sign correction and result select
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_result;

    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_quo  = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_result = '0;
        case (r_op)
            c_op_mul:                           w_result = w_prod[WIDTH-1:0];
            c_op_mulh, c_op_mulhsu, c_op_mulhu: w_result = w_prod[2*WIDTH-1:WIDTH];
            c_op_div, c_op_divu:                w_result = w_quo;
            c_op_rem, c_op_remu:                w_result = w_rem;
            default:                            w_result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (!w_valid || w_special) ? c_st_done : c_st_calc;
                end
            end
            c_st_calc: begin
                busy = 1'b1;
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = c_st_fix;
                end
            end
            c_st_fix: begin
                busy        = 1'b1;
                w_state_nxt = c_st_done;
            end
            c_st_done: begin
                done = 1'b1;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (!w_valid || w_special) ? c_st_done : c_st_calc;
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    assign error    = done & r_err;
    assign mul_dout = r_dout;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_op      <= '0;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_err     <= 1'b0;
            r_opd     <= '0;
            r_acc     <= '0;
            r_dout    <= '0;
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_op      <= w_op;
            r_neg     <= w_s1 ^ w_s2;
            r_neg_rem <= w_s1;
            r_err     <= ~w_valid;
            r_opd     <= w_is_div ? w_mag2 : w_mag1;
            r_acc     <= {{WIDTH{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
            if (!w_valid) begin
                r_dout <= '0;
            end else if (w_special) begin
                r_dout <= w_special_res;
            end
        end else if (r_state == c_st_calc) begin
            r_acc <= r_op[2] ? w_div_nxt : w_mul_nxt;
            r_cnt <= r_cnt + c_cnt_w'(1);
        end else if (r_state == c_st_fix) begin
            r_dout <= w_result;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Directed self-checking bench for mul_div_unit with
//               hand-computed expected results, latencies and busy counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  mode_sel;
    logic [31:0] num1;
    logic [31:0] num2;
    logic [31:0] mul_dout;
    logic        busy;
    logic        done;
    logic        error;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32), .ITER(32)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode_sel (mode_sel),
        .num1     (num1),
        .num2     (num2),
        .mul_dout (mul_dout),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one start pulse; returns at 1 time unit after the accepting edge.
    task automatic issue(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start    = 1'b1;
        mode_sel = m;
        num1     = a;
        num2     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done is seen, plus the sampled cycles with busy high.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = 0;
        while (!done && edges < 200) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic run(input string tag, input logic [7:0] m, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_edges);
        int e;
        int bc;
        issue(m, a, b);
        wait_done(e, bc);
        check({tag, "_lat"}, e, exp_edges);
        check({tag, "_busy"}, bc, exp_edges);
        check({tag, "_dout"}, mul_dout, exp);
        check({tag, "_err"}, {31'b0, error}, 32'd0);
    endtask

    initial begin
        int e;
        int bc;
        int seen;

        rst      = 1'b1;
        start    = 1'b0;
        mode_sel = 8'h00;
        num1     = '0;
        num2     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, error}, 32'd0);
        check("rst_dout", mul_dout, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Multiplies
        run("mul",    8'h20, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        run("mulh",   8'h21, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        run("mulhu",  8'h23, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run("mulhsu", 8'h22, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);

        // Signed divides
        run("div", 8'h24, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        run("rem", 8'h26, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);

        // Special cases resolve in the cycle after issue
        run("divu0",  8'h25, 32'd5,        32'd0,        32'hFFFFFFFF, 0);
        run("remu0",  8'h27, 32'd5,        32'd0,        32'd5,        0);
        run("divovf", 8'h24, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        run("removf", 8'h26, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0);

        // start while busy is ignored; operand changes have no effect
        issue(8'h23, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start    = 1'b1;
        mode_sel = 8'h24;
        num1     = 32'd5;
        num2     = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(e, bc);
        check("ign_lat", e, 28);
        check("ign_dout", mul_dout, 32'hFFFFFFFE);

        // Back-to-back: new start issued during the DONE cycle
        issue(8'h20, 32'd7, 32'hFFFFFFFD);
        wait_done(e, bc);
        check("b2b_first_done", {31'b0, done}, 32'd1);
        check("b2b_first_dout", mul_dout, 32'hFFFFFFEB);
        run("b2b_second", 8'h25, 32'd100, 32'd7, 32'd14, 33);

        // Asynchronous reset in the middle of a DIVU
        issue(8'h25, 32'hFFFFFFFF, 32'd3);
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_dout", mul_dout, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("arst_no_done", seen, 0);
        run("post_rst", 8'h25, 32'd100, 32'd7, 32'd14, 33);

        // Unsupported code
        issue(8'h30, 32'd3, 32'd4);
        check("inv_done", {31'b0, done}, 32'd1);
        check("inv_err", {31'b0, error}, 32'd1);
        check("inv_dout", mul_dout, 32'd0);
        check("inv_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check("inv_done_clr", {31'b0, done}, 32'd0);
        check("inv_err_clr", {31'b0, error}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide unit. It produces the `mul_din` operand that the ALU selects for M-extension results.
- Takes the same `num1`/`num2` source operands and an 8-bit `mode_sel` from decode, and runs a start/busy/done handshake.
- Multi-cycle radix-2 datapath: one bit per clock. Sign correction is done in a separate final cycle.

Parameters:
- WIDTH, 32, operand and result width; only 32 is supported.
- ITER, 32, iteration count in CALC; must equal WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy==0.
- mode_sel  input  8  operation code, sampled with start.
- num1  input  32  multiplicand / dividend, sampled with start.
- num2  input  32  multiplier / divisor, sampled with start.
- mul_dout  output  32  result; drives ALU mul_din; held until the next completion.
- busy  output  1  high in CALC and FIX.
- done  output  1  one-cycle completion pulse.
- error  output  1  one-cycle pulse; unsupported mode_sel.

Behaviour:
- Mode codes:
  - MUL 8'h20 (low 32 bits), MULH 8'h21 (signed x signed, high), MULHSU 8'h22 (signed num1 x unsigned num2, high), MULHU 8'h23 (unsigned, high).
  - DIV 8'h24, DIVU 8'h25, REM 8'h26, REMU 8'h27.
  - Any other code with start: mul_dout<=0, error=1 and done=1 for one cycle (state DONE), no computation.
- Reset (async, any state): state IDLE; mul_dout=0, busy=0, done=0, error=0; internal counters/accumulators cleared. An in-flight operation is discarded and done is never raised for it.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + start (edge E0):
  - Latch operands, mode, operand signs and magnitudes (two's-complement absolute value for signed operands).
  - Special cases go directly to DONE with the result loaded at E0, giving done high for the cycle after E0 (latency 1):
    - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> num1.
    - Signed overflow: DIV with num1=0x80000000 and num2=0xFFFFFFFF -> 0x80000000; REM -> 0.
  - Otherwise -> CALC with counter=0.
- CALC, one iteration per edge, counter 0..31; the counter==31 edge (E32) moves to FIX:
  - Multiply: shift-add on magnitudes into a 64-bit accumulator.
  - Divide: restoring algorithm; shift the remainder left and bring in the next dividend bit; subtract the divisor when remainder >= divisor, setting the quotient bit.
- FIX (edge E33):
  - Product is negated (64-bit) if sign(num1) xor sign(num2) for MULH/MULHSU; MUL behaves the same (low word is sign-agnostic).
  - Quotient is negated if signs differ (DIV).
  - Remainder takes the sign of the dividend (REM).
  - Select the low/high word or quotient/remainder, load mul_dout, -> DONE.
- Normal latency: done high in the cycle after E33, i.e. 33 cycles after start is sampled.
- DONE: lasts one cycle; done=1 (error=1 only for an invalid code). Next edge -> IDLE, unless start is present, which is accepted (back-to-back issue, new op begins).
- busy=1 only in CALC/FIX. start while busy is ignored with no side effects. Operand/mode changes while busy have no effect.
- mul_dout changes only at the completion edge (or reset) and holds between operations.

Test Plan:
- Multiplies, each: start with the given operands -> done after 33 cycles with the stated mul_dout.
  - MUL, num1=7, num2=0xFFFFFFFD (-3) -> mul_dout=0xFFFFFFEB.
  - MULH, 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divides: num1=0xFFFFFFF9 (-7), num2=2.
  - DIV -> mul_dout=0xFFFFFFFD.
  - REM -> mul_dout=0xFFFFFFFF; latency 33; busy high exactly 32+1 cycles.
- Special cases, each: done after 1 cycle, busy never set.
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- Handshake:
  - Start MULHU; pulse start with different operands at cycle 5 -> ignored, result still 0xFFFFFFFE.
  - start asserted during DONE -> second op accepted, done again 33 cycles later.
- Reset and invalid code:
  - Assert rst at cycle 10 of a DIVU -> busy/done/mul_dout=0 immediately; a fresh DIVU 100/7 after release -> 14.
  - mode_sel=8'h30 with start -> error=1 and done=1 for one cycle, mul_dout=0.
